// File: rtl/bin_to_bcd_serial.sv
// Iterative double-dabble binary-to-BCD converter: one input bit per clock,
// result and overflow flag held in output registers until the next completion.
module bin_to_bcd_serial #(
  parameter int WIDTH       = 32,
  parameter int DIGITS      = 10,
  parameter int DISP_DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t               state, state_next;
  logic [CNT_W-1:0]     cnt;
  logic [BCD_W-1:0]     bcd_q, bcd_adj;
  logic [WIDTH-1:0]     bin_q;
  logic [BCD_W+WIDTH-1:0] shifted;
  logic                 load, last;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  // Add-3 correction on every digit in parallel, then one left shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5)
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    shifted = {bcd_adj, bin_q} << 1;
  end

  assign busy = (state == SHIFT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      bcd_q   <= '0;
      bin_q   <= '0;
      bcd_out <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        cnt   <= '0;
        bcd_q <= '0;
        bin_q <= bin_in;
      end else if (busy) begin
        cnt   <= cnt + CNT_W'(1);
        bcd_q <= shifted[BCD_W+WIDTH-1:WIDTH];
        bin_q <= shifted[WIDTH-1:0];
      end
      if (last) begin
        bcd_out <= shifted[BCD_W+WIDTH-1:WIDTH];
        ovf     <= |shifted[BCD_W+WIDTH-1:WIDTH+4*DISP_DIGITS];
        done    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
// Self-checking bench for bin_to_bcd_serial: directed table, held-start mode,
// mid-conversion disturbance and reset, and random values against a decimal model.
module tb_bin_to_bcd_serial;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] bin_in = '0;
  logic        busy, done, ovf;
  logic [39:0] bcd_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  bin_to_bcd_serial #(.WIDTH(32), .DIGITS(10), .DISP_DIGITS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] bin;
    logic [39:0] bcd;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal model: repeated division by ten, digit k into nibble k.
  function automatic logic [39:0] model_bcd(input logic [31:0] v);
    longint x = longint'(v);
    logic [39:0] r = '0;
    for (int k = 0; k < 10; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input logic [31:0] v);
    return longint'(v) >= 64'd100000000;
  endfunction

  // Starts one conversion and waits for done. disturb_at >= 0 pulses start and
  // changes bin_in that many cycles after capture. held_ok reports whether
  // bcd_out kept its previous value until done.
  task automatic run_conv(input logic [31:0] v, input int disturb_at,
                          output logic [39:0] res, output logic res_ovf,
                          output int lat, output int busy_cycles, output logic held_ok);
    logic [39:0] prev;
    @(negedge clk);
    prev   = bcd_out;
    bin_in = v;
    start  = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
    lat         = 0;
    busy_cycles = 0;
    held_ok     = 1'b1;
    while (!done && lat < 100) begin
      if (busy) busy_cycles++;
      if (bcd_out !== prev) held_ok = 1'b0;
      if (lat == disturb_at) begin
        bin_in = $urandom;
        start  = 1'b1;
      end else if (lat == disturb_at + 1) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start   = 1'b0;
    res     = bcd_out;
    res_ovf = ovf;
  endtask

  vec_t        vecs[8];
  logic [39:0] res;
  logic        res_ovf, held_ok, saw_done;
  int          lat, bcyc, last_done;
  logic [31:0] seq[5];

  initial begin
    vecs[0] = '{32'd0,         40'h0000000000, 1'b0};
    vecs[1] = '{32'd12345678,  40'h0012345678, 1'b0};
    vecs[2] = '{32'd99999999,  40'h0099999999, 1'b0};
    vecs[3] = '{32'd100000000, 40'h0100000000, 1'b1};
    vecs[4] = '{32'hFFFFFFFF,  40'h4294967295, 1'b1};
    vecs[5] = '{32'd9,         40'h0000000009, 1'b0};
    vecs[6] = '{32'd10,        40'h0000000010, 1'b0};
    vecs[7] = '{32'd55,        40'h0000000055, 1'b0};

    // Reset state
    #23;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    check("reset_bcd", 64'(bcd_out), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed table
    foreach (vecs[i]) begin
      run_conv(vecs[i].bin, -1, res, res_ovf, lat, bcyc, held_ok);
      check($sformatf("tbl%0d_bcd", i), 64'(res), 64'(vecs[i].bcd));
      check($sformatf("tbl%0d_ovf", i), 64'(res_ovf), 64'(vecs[i].ovf));
      check($sformatf("tbl%0d_latency", i), 64'(lat), 64'd32);
      check($sformatf("tbl%0d_busy_cycles", i), 64'(bcyc), 64'd32);
      check($sformatf("tbl%0d_held", i), 64'(held_ok), 64'd1);
      @(posedge clk); #1;
      check($sformatf("tbl%0d_done_pulse", i), 64'(done), 64'd0);
    end

    // Start pulse and bin_in change mid-conversion are ignored
    run_conv(32'd12345678, 10, res, res_ovf, lat, bcyc, held_ok);
    check("disturb_bcd", 64'(res), 64'h0012345678);
    check("disturb_latency", 64'(lat), 64'd32);
    @(posedge clk); #1;
    check("disturb_no_restart", 64'(busy), 64'd0);

    // Held start: free-running, one result every 33 cycles
    seq = '{32'd7, 32'd42, 32'd7, 32'd42, 32'd7};
    @(negedge clk);
    bin_in = seq[0];
    start  = 1'b1;
    last_done = 0;
    for (int i = 0; i < 5; i++) begin
      lat = 0;
      @(posedge clk); #1;
      while (!done && lat < 100) begin
        if (lat == 15) bin_in = 32'hDEADBEEF;
        @(posedge clk); #1;
        lat++;
      end
      check($sformatf("held%0d_bcd", i), 64'(bcd_out), 64'(model_bcd(seq[i])));
      if (i > 0) check($sformatf("held%0d_period", i), 64'(cyc - last_done), 64'd33);
      last_done = cyc;
      if (i < 4) bin_in = seq[i+1];
      else       start = 1'b0;
    end
    @(posedge clk); #1;
    check("held_stop", 64'(busy), 64'd0);

    // Reset in the middle of a conversion
    @(negedge clk);
    bin_in = 32'd55;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_bcd", 64'(bcd_out), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("midrst_no_done", 64'(saw_done), 64'd0);
    run_conv(32'd55, -1, res, res_ovf, lat, bcyc, held_ok);
    check("after_rst_bcd", 64'(res), 64'h55);

    // Random values against the decimal model, back to back
    for (int i = 0; i < 30; i++) begin
      logic [31:0] v;
      v = $urandom;
      if (v < 32'd1000) v = v + 32'd1000;
      run_conv(v, -1, res, res_ovf, lat, bcyc, held_ok);
      check($sformatf("rnd%0d_bcd(%0d)", i, v), 64'(res), 64'(model_bcd(v)));
      check($sformatf("rnd%0d_ovf(%0d)", i, v), 64'(res_ovf), 64'(model_ovf(v)));
      check($sformatf("rnd%0d_held", i), 64'(held_ok), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
